// File: rtl/spi_master_io.sv
// spi_master_io: memory-mapped SPI mode-0 byte shifter for the j1 IO bus.
// The core decodes two IO addresses. One is a data register: a write starts a
// transfer and a read returns the received byte. The other is a
// control/status register. The core drives the flash pins directly and
// returns read data on a bus that the top level ORs into io_din.
module spi_master_io #(
    parameter logic [15:0] ADDR_DATA = 16'd320,
    parameter logic [15:0] ADDR_CTRL = 16'd321,
    parameter logic [7:0]  CLKDIV    = 8'd2
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] rd_data,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        cs_q, cs_d;
    logic        done_q, done_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  divcnt_q, divcnt_d;
    logic        mosi_q, mosi_d;

    logic        sel_data;
    logic        sel_ctrl;
    logic        div_last;
    logic        unused_dout_hi;

    assign sel_data       = (mem_addr == ADDR_DATA);
    assign sel_ctrl       = (mem_addr == ADDR_CTRL);
    assign div_last       = (divcnt_q == (CLKDIV - 8'd1));
    assign unused_dout_hi = ^dout[15:8];

    assign busy     = (state_q != IDLE);
    assign spi_sck  = (state_q == SHIFT_HI);
    assign spi_cs_n = ~cs_q;
    assign spi_mosi = mosi_q;

    // Next-state logic: bus decode, bit timing and shifting; completion overrides a same-cycle read clear of done
    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_byte_d = rx_byte_q;
        cs_d      = cs_q;
        done_d    = done_q;
        bitcnt_d  = bitcnt_q;
        divcnt_d  = divcnt_q;

        if (io_rd && sel_data) begin
            done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (io_wr && sel_ctrl) begin
                    cs_d = dout[0];
                end
                if (io_wr && sel_data) begin
                    tx_sr_d  = dout[7:0];
                    bitcnt_d = 3'd0;
                    divcnt_d = 8'd0;
                    done_d   = 1'b0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    divcnt_d = 8'd0;
                    rx_sr_d  = {rx_sr_q[6:0], spi_miso};
                    state_d  = SHIFT_HI;
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    divcnt_d = 8'd0;
                    if (bitcnt_q == 3'd7) begin
                        rx_byte_d = rx_sr_q;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tx_sr_d  = {tx_sr_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 3'd1;
                        state_d  = SHIFT_LO;
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mosi_d = mosi_q;
        if (state_d != IDLE) begin
            mosi_d = tx_sr_d[7];
        end
    end

    // Read-back mux: zero unless one of our two addresses is selected
    always_comb begin
        rd_data = 16'd0;
        if (sel_data) begin
            rd_data = {8'd0, rx_byte_q};
        end else if (sel_ctrl) begin
            rd_data = {13'd0, done_q, busy, cs_q};
        end
    end

    // State registers with synchronous active-low reset that aborts any transfer
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q   <= IDLE;
            tx_sr_q   <= 8'd0;
            rx_sr_q   <= 8'd0;
            rx_byte_q <= 8'd0;
            cs_q      <= 1'b0;
            done_q    <= 1'b0;
            bitcnt_q  <= 3'd0;
            divcnt_q  <= 8'd0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_byte_q <= rx_byte_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
            bitcnt_q  <= bitcnt_d;
            divcnt_q  <= divcnt_d;
            mosi_q    <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_master_io.sv
// tb_spi_master_io: self-checking bench for spi_master_io.
// Two DUTs, with CLKDIV=2 and CLKDIV=1, share the CPU-side stimulus.
// 'sel' picks which DUT's outputs the checks observe.
// Each DUT has its own slave model.
module tb_spi_master_io;

    localparam logic [15:0] A_DATA = 16'd320;
    localparam logic [15:0] A_CTRL = 16'd321;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [15:0] mem_addr = 16'd0;
    logic [15:0] dout = 16'd0;

    logic [15:0] rd2, rd1;
    logic        sck2, sck1, mosi2, mosi1, miso2, miso1, csn2, csn1, busy2, busy1;

    logic        sel = 1'b0;
    logic        loop_mode = 1'b1;
    logic [7:0]  slave_byte = 8'd0;
    logic [2:0]  rc2 = 3'd0;
    logic [2:0]  rc1 = 3'd0;

    int          total = 0;
    int          bad = 0;
    logic        exp_cs = 1'b0;
    logic [7:0]  last_rx = 8'd0;

    wire [15:0] s_rd   = sel ? rd1 : rd2;
    wire        s_sck  = sel ? sck1 : sck2;
    wire        s_mosi = sel ? mosi1 : mosi2;
    wire        s_csn  = sel ? csn1 : csn2;
    wire        s_busy = sel ? busy1 : busy2;
    wire [7:0]  s_cd   = sel ? 8'd1 : 8'd2;

    spi_master_io #(.CLKDIV(8'd2)) dut2 (
        .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
        .mem_addr(mem_addr), .dout(dout), .rd_data(rd2),
        .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(miso2),
        .spi_cs_n(csn2), .busy(busy2)
    );

    spi_master_io #(.CLKDIV(8'd1)) dut1 (
        .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
        .mem_addr(mem_addr), .dout(dout), .rd_data(rd1),
        .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1),
        .spi_cs_n(csn1), .busy(busy1)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Slave bit counters: advance on each SCK rise, cleared when a transfer ends
    always @(posedge sck2 or negedge busy2) begin
        if (!busy2) rc2 <= 3'd0;
        else        rc2 <= rc2 + 3'd1;
    end

    always @(posedge sck1 or negedge busy1) begin
        if (!busy1) rc1 <= 3'd0;
        else        rc1 <= rc1 + 3'd1;
    end

    assign miso2 = loop_mode ? mosi2 : slave_byte[3'd7 - rc2];
    assign miso1 = loop_mode ? mosi1 : slave_byte[3'd7 - rc1];

    // One-cycle IO write, driven just after a falling edge
    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        io_wr    = 1'b1;
        mem_addr = addr;
        dout     = data;
        @(negedge clk);
        io_wr    = 1'b0;
    endtask

    // One-cycle DATA read strobe (clears done)
    task automatic do_read_data();
        io_rd    = 1'b1;
        mem_addr = A_DATA;
        @(negedge clk);
        io_rd    = 1'b0;
    endtask

    // Bounded wait for the observed DUT to go idle
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (s_busy === 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (s_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s idle_timeout busy=%b after %0d cycles", tag, s_busy, n);
        end
    endtask

    // Full transfer with monitoring of SCK, MOSI and busy against the byte-level model
    task automatic run_transfer(input logic [7:0] tx, input logic loop, input logic [7:0] slv, input string tag);
        int cycles, rises, badrun, badmosi, run;
        logic prev_sck, prev_mosi;
        logic [7:0] seq, exp_rx;
        loop_mode  = loop;
        slave_byte = slv;
        exp_rx     = loop ? tx : slv;
        do_write(A_DATA, {8'd0, tx});
        total++;
        if (s_busy !== 1'b1 || s_mosi !== tx[7]) begin
            bad++;
            $display("[TB] FAIL %s start busy=%b mosi=%b want busy=1 mosi=%b", tag, s_busy, s_mosi, tx[7]);
        end
        cycles = 0; rises = 0; badrun = 0; badmosi = 0; run = 0;
        seq = 8'd0; prev_sck = 1'b0; prev_mosi = s_mosi;
        while (s_busy === 1'b1 && cycles < 6000) begin
            if (s_sck !== prev_sck) begin
                if (run != int'(s_cd)) badrun++;
                if (s_sck === 1'b1) begin
                    seq = {seq[6:0], s_mosi};
                    rises++;
                end
                run = 0;
            end
            if (cycles > 0 && s_mosi !== prev_mosi && !(prev_sck === 1'b1 && s_sck === 1'b0)) badmosi++;
            run++;
            prev_sck  = s_sck;
            prev_mosi = s_mosi;
            cycles++;
            @(negedge clk);
        end
        if (run != int'(s_cd)) badrun++;
        total++;
        if (cycles != 16 * int'(s_cd)) begin
            bad++;
            $display("[TB] FAIL %s busy_len got=%0d want=%0d", tag, cycles, 16 * int'(s_cd));
        end
        total++;
        if (rises != 8) begin
            bad++;
            $display("[TB] FAIL %s sck_rises got=%0d want=8", tag, rises);
        end
        total++;
        if (seq !== tx) begin
            bad++;
            $display("[TB] FAIL %s mosi_seq got=%h want=%h", tag, seq, tx);
        end
        total++;
        if (badrun != 0 || badmosi != 0) begin
            bad++;
            $display("[TB] FAIL %s sck_duty/mosi_edge bad_runs=%0d bad_mosi=%0d want 0/0", tag, badrun, badmosi);
        end
        total++;
        if (s_mosi !== tx[0] || s_sck !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s idle_pins mosi=%b sck=%b want mosi=%b sck=0", tag, s_mosi, s_sck, tx[0]);
        end
        mem_addr = A_CTRL;
        #1;
        total++;
        if (s_rd !== {13'd0, 1'b1, 1'b0, exp_cs}) begin
            bad++;
            $display("[TB] FAIL %s ctrl_done got=%h want=%h", tag, s_rd, {13'd0, 1'b1, 1'b0, exp_cs});
        end
        mem_addr = A_DATA;
        #1;
        total++;
        if (s_rd !== {8'd0, exp_rx}) begin
            bad++;
            $display("[TB] FAIL %s rx_byte got=%h want=%h", tag, s_rd, {8'd0, exp_rx});
        end
        last_rx = exp_rx;
        do_read_data();
        mem_addr = A_CTRL;
        #1;
        total++;
        if (s_rd !== {15'd0, exp_cs}) begin
            bad++;
            $display("[TB] FAIL %s ctrl_after_read got=%h want=%h", tag, s_rd, {15'd0, exp_cs});
        end
        @(negedge clk);
    endtask

    // Power-on state, then a reset that aborts a transfer in progress
    task automatic test_reset();
        mem_addr = A_CTRL;
        #1;
        total++;
        if (s_rd !== 16'h0000 || s_csn !== 1'b1 || s_sck !== 1'b0 || s_busy !== 1'b0 || s_mosi !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_pon ctrl=%h csn=%b sck=%b busy=%b mosi=%b want 0000/1/0/0/0",
                     s_rd, s_csn, s_sck, s_busy, s_mosi);
        end
        @(negedge clk);
        loop_mode = 1'b1;
        do_write(A_CTRL, 16'd1);
        do_write(A_DATA, 16'h00C3);
        repeat (5) @(negedge clk);
        resetq = 1'b0;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        exp_cs  = 1'b0;
        last_rx = 8'd0;
        mem_addr = A_CTRL;
        #1;
        total++;
        if (s_rd !== 16'h0000 || s_csn !== 1'b1 || s_sck !== 1'b0 || s_busy !== 1'b0 || s_mosi !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid ctrl=%h csn=%b sck=%b busy=%b mosi=%b want 0000/1/0/0/0",
                     s_rd, s_csn, s_sck, s_busy, s_mosi);
        end
        mem_addr = A_DATA;
        #1;
        total++;
        if (s_rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_rx got=%h want=0000", s_rd);
        end
        repeat (40) @(negedge clk);
        mem_addr = A_CTRL;
        #1;
        total++;
        if (s_rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_no_done got=%h want=0000", s_rd);
        end
        mem_addr = 16'd319;
        #1;
        total++;
        if (s_rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL other_addr got=%h want=0000", s_rd);
        end
        @(negedge clk);
    endtask

    // Chip select follows a CTRL write on the next cycle
    task automatic test_ctrl();
        do_write(A_CTRL, 16'd1);
        exp_cs = 1'b1;
        total++;
        if (s_csn !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ctrl_cs got=%b want=0", s_csn);
        end
    endtask

    // Fixed-pattern loopback and slave transfers
    task automatic test_loopback();
        run_transfer(8'hA5, 1'b1, 8'h00, "loop_a5");
        run_transfer(8'hFF, 1'b0, 8'h3C, "slave_3c");
    endtask

    // DATA and CTRL writes while busy are ignored
    task automatic test_ignore();
        int csn_bad;
        loop_mode = 1'b1;
        do_write(A_DATA, 16'h0012);
        do_write(A_DATA, 16'h0055);
        do_write(A_CTRL, 16'h0000);
        csn_bad = 0;
        for (int i = 0; i < 6000 && s_busy === 1'b1; i++) begin
            if (s_csn !== 1'b0) csn_bad++;
            @(negedge clk);
        end
        wait_idle("ignore");
        total++;
        if (csn_bad != 0 || s_csn !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ignore_cs bad_cycles=%0d csn=%b want 0/0", csn_bad, s_csn);
        end
        mem_addr = A_DATA;
        #1;
        total++;
        if (s_rd !== 16'h0012) begin
            bad++;
            $display("[TB] FAIL ignore_rx got=%h want=0012", s_rd);
        end
        last_rx = 8'h12;
        mem_addr = A_CTRL;
        #1;
        total++;
        if (s_rd !== 16'h0005) begin
            bad++;
            $display("[TB] FAIL ignore_ctrl got=%h want=0005", s_rd);
        end
        do_read_data();
    endtask

    // Read colliding with completion, then an immediate next transfer
    task automatic test_back_to_back();
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        loop_mode = 1'b1;
        do_write(A_DATA, {8'd0, a});
        repeat (16 * int'(s_cd) - 1) @(negedge clk);
        total++;
        if (s_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_last_busy got=%b want=1", s_busy);
        end
        io_rd    = 1'b1;
        mem_addr = A_DATA;
        #1;
        total++;
        if (s_rd !== {8'd0, last_rx}) begin
            bad++;
            $display("[TB] FAIL b2b_old_byte got=%h want=%h", s_rd, {8'd0, last_rx});
        end
        @(negedge clk);
        io_rd    = 1'b0;
        mem_addr = A_CTRL;
        #1;
        total++;
        if (s_rd !== {13'd0, 1'b1, 1'b0, exp_cs}) begin
            bad++;
            $display("[TB] FAIL b2b_done_kept got=%h want=%h", s_rd, {13'd0, 1'b1, 1'b0, exp_cs});
        end
        mem_addr = A_DATA;
        #1;
        total++;
        if (s_rd !== {8'd0, a}) begin
            bad++;
            $display("[TB] FAIL b2b_first_rx got=%h want=%h", s_rd, {8'd0, a});
        end
        last_rx = a;
        do_write(A_DATA, {8'd0, b});
        total++;
        if (s_busy !== 1'b1 || s_mosi !== b[7]) begin
            bad++;
            $display("[TB] FAIL b2b_no_gap busy=%b mosi=%b want 1/%b", s_busy, s_mosi, b[7]);
        end
        wait_idle("b2b");
        mem_addr = A_DATA;
        #1;
        total++;
        if (s_rd !== {8'd0, b}) begin
            bad++;
            $display("[TB] FAIL b2b_second_rx got=%h want=%h", s_rd, {8'd0, b});
        end
        last_rx = b;
        do_read_data();
    endtask

    // Random bytes in random loopback / slave modes
    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            run_transfer(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), "random");
        end
    endtask

    // Fastest divider: SCK toggles every clk cycle
    task automatic test_clkdiv1();
        sel = 1'b1;
        resetq = 1'b0;
        repeat (3) @(negedge clk);
        resetq  = 1'b1;
        exp_cs  = 1'b0;
        last_rx = 8'd0;
        @(negedge clk);
        test_ctrl();
        run_transfer(8'hA5, 1'b1, 8'h00, "div1_a5");
        test_random(3);
        test_back_to_back();
    endtask

    // Test sequence
    initial begin
        @(negedge clk);
        resetq = 1'b0;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        test_reset();
        test_ctrl();
        test_loopback();
        test_ignore();
        test_back_to_back();
        test_random(4);
        test_clkdiv1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_io.md
# spi_master_io

Memory-mapped SPI master on the j1 IO bus, replacing the bit-banged flash access through the PIOS register with a hardware byte shifter. It decodes its own two IO addresses from `mem_addr`, shifts one byte per CPU write in SPI mode 0 (MSB first), and returns received data and status on a read bus that top-level ORs into `io_din`. It drives the external flash pins (SPICLK, SPISI, SPISSB, SPISO) directly.

## Interface
Parameters:
- `ADDR_DATA`, 16'd320, IO address of the TX/RX data register
- `ADDR_CTRL`, 16'd321, IO address of the control/status register
- `CLKDIV`, 8'd2, SCK half-period in `clk` cycles; legal range 1..255

Ports:
- `clk` in 1 system clock (oscillator, 30 MHz)
- `resetq` in 1 reset: synchronous, active-low
- `io_wr` in 1 CPU IO write strobe, one cycle
- `io_rd` in 1 CPU IO read strobe, one cycle
- `mem_addr` in 16 CPU IO address
- `dout` in 16 CPU write data
- `rd_data` out 16 read data, 16'd0 unless `mem_addr` equals `ADDR_DATA` or `ADDR_CTRL`
- `spi_sck` out 1 serial clock, idles low
- `spi_mosi` out 1 serial data to slave
- `spi_miso` in 1 serial data from slave
- `spi_cs_n` out 1 chip select, active-low
- `busy` out 1 high while a byte transfer is in progress

## Operation
- Registers: `tx_sr[7:0]`, `rx_sr[7:0]`, `rx_byte[7:0]`, `cs` (1 = asserted), `done` (sticky), `bitcnt[2:0]`, `divcnt[7:0]`, state.
- CTRL write (`io_wr` & addr==`ADDR_CTRL`): `cs <= dout[0]` only when IDLE; ignored when busy. `spi_cs_n = ~cs`.
- CTRL read value: {13'd0, done, busy, cs}.
- DATA write in IDLE: `tx_sr <= dout[7:0]`, `bitcnt <= 0`, `divcnt <= 0`, `done <= 0`, enter SHIFT_LO. DATA write while busy: ignored entirely (no restart, no data change).
- DATA read value: {8'd0, rx_byte}. DATA read (`io_rd`) clears `done`.
- CS is not touched by transfers; software frames multi-byte commands.
- States:
  - IDLE: `spi_sck`=0, `busy`=0.
  - SHIFT_LO: `spi_sck`=0, `spi_mosi`=`tx_sr[7]`; when `divcnt`==CLKDIV-1: `divcnt`<=0, sample `spi_miso` into `rx_sr` LSB (shift left), go SHIFT_HI.
  - SHIFT_HI: `spi_sck`=1; when `divcnt`==CLKDIV-1: `divcnt`<=0; if `bitcnt`==7 then `rx_byte`<=`rx_sr`, `done`<=1, go IDLE; else `tx_sr`<=`tx_sr`<<1, `bitcnt`++, go SHIFT_LO.
- `spi_mosi` holds its last value in IDLE.
- Simultaneous DATA read and transfer completion: read returns previous `rx_byte`; `done` ends set (completion wins).
- Reset (any state, including mid-transfer): state IDLE, `spi_sck`=0, `spi_mosi`=0, `cs`=0 (`spi_cs_n`=1), `busy`=0, `done`=0, `rx_byte`=0, `tx_sr`=0, `rx_sr`=0. An aborted transfer produces no `done`.

## Timing
- `rd_data` is combinational from `mem_addr` and registers, valid in the same cycle as `io_rd`.
- DATA write sampled at edge N: `busy`=1 and `spi_mosi`=bit7 from cycle N+1.
- First SCK rise occurs CLKDIV cycles after N+1. MISO is sampled on the `clk` edge that raises SCK.
- Each bit takes 2·CLKDIV cycles, so `busy` is high for exactly 16·CLKDIV cycles.
- `done`=1 and `rx_byte` are valid in the first cycle after `busy` falls. A new DATA write is accepted in that same cycle.
- SCK duty cycle is exactly 50%. MOSI changes only on SCK falling edges, or at transfer start.
- CTRL write takes effect on `spi_cs_n` in the next cycle.

## Test plan
- Reset: hold `resetq`=0 for 3 cycles mid-transfer -> next cycle `spi_cs_n`=1, `spi_sck`=0, `busy`=0, CTRL reads 16'h0000.
- Loopback (`spi_miso` tied to `spi_mosi`), CLKDIV=2: write CTRL 1, write DATA 16'h00A5 -> `busy` high for 32 cycles, 8 SCK rises, MOSI sequence 1,0,1,0,0,1,0,1; CTRL reads 16'h0005; DATA reads 16'h00A5; CTRL then reads 16'h0001.
- Slave model returning 8'h3C, with 16'h00FF written -> DATA reads 16'h003C; MOSI held high for all 8 bits.
- Write DATA 16'h0055 during a busy transfer of 16'h0012, and write CTRL 0 during the same transfer -> both ignored; loopback result 16'h0012; `spi_cs_n` stays 0.
- Same-cycle completion and DATA read -> read returns the old byte; `done` remains 1. A DATA write in the cycle after `busy` falls starts the next transfer with no gap.
- CLKDIV=1 -> `busy` high for 16 cycles; SCK toggles every cycle; loopback byte correct.
